// File: rtl/mimc_pkg.sv
// Shared definitions for the MiMC round datapath: BN254 scalar-field prime,
// default field width and the serial multiplier state encoding.
package mimc_pkg;

  localparam int N_BITS_DEFAULT = 254;

  localparam logic [N_BITS_DEFAULT-1:0] BN254_PRIME =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_t;

endpackage : mimc_pkg

// File: rtl/galois_add.sv
// Combinational modular adder over GF(PRIME_MODULUS).
// Both operands must already be reduced (< PRIME_MODULUS), so the raw sum is
// below 2p and a single conditional subtract of p is exact.
module galois_add
  import mimc_pkg::*;
#(
  parameter int                N_BITS        = N_BITS_DEFAULT,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = BN254_PRIME
) (
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic [N_BITS-1:0] sum
);

  logic [N_BITS:0] raw_sum;
  logic [N_BITS:0] reduced;

  // One extra bit holds the carry; the top bit of (raw_sum - p) is the borrow,
  // which is set exactly when raw_sum < p because p < 2**N_BITS.
  always_comb begin
    raw_sum = {1'b0, a} + {1'b0, b};
    reduced = raw_sum - {1'b0, PRIME_MODULUS};
    sum     = reduced[N_BITS] ? raw_sum[N_BITS-1:0] : reduced[N_BITS-1:0];
  end

endmodule : galois_add

// File: rtl/galois_mult_serial.sv
// Bit-serial modular multiplier over GF(PRIME_MODULUS), MSB-first
// double-and-add, one multiplication in flight, valid/ready on both sides.
// Optional feature macro: GALOIS_MULT_EARLY_EXIT_EN -- start the scan at the
// highest set bit of num2 instead of a fixed N_BITS-cycle (constant-time) run.
module galois_mult_serial
  import mimc_pkg::*;
#(
  parameter int                N_BITS        = N_BITS_DEFAULT,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = BN254_PRIME
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] num1,
  input  logic [N_BITS-1:0] num2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] product,
  output logic              busy
);

  localparam int CNT_W = $clog2(N_BITS);

  mult_state_t       state_q;
  logic [N_BITS-1:0] a_q;
  logic [N_BITS-1:0] b_q;
  logic [N_BITS-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [N_BITS-1:0] dbl;
  logic [N_BITS-1:0] dbl_add;
  logic [N_BITS-1:0] acc_next;

  // Doubler followed by the conditional adder; both stay reduced mod p.
  galois_add #(
    .N_BITS        (N_BITS),
    .PRIME_MODULUS (PRIME_MODULUS)
  ) u_double (
    .a   (acc_q),
    .b   (acc_q),
    .sum (dbl)
  );

  galois_add #(
    .N_BITS        (N_BITS),
    .PRIME_MODULUS (PRIME_MODULUS)
  ) u_add (
    .a   (dbl),
    .b   (a_q),
    .sum (dbl_add)
  );

  // Current multiplier bit picks double-and-add or plain double.
  assign acc_next = b_q[cnt_q] ? dbl_add : dbl;

`ifdef GALOIS_MULT_EARLY_EXIT_EN
  logic [CNT_W-1:0] msb_idx;

  // Priority encoder: index of the highest set bit of num2. num2==0 encodes
  // as 0, so a single RUN cycle doubles a zero accumulator and out_valid
  // rises one cycle after accept with product 0.
  always_comb begin
    // NOTE: assign a default before the loop so no path leaves msb_idx
    // unassigned, which would otherwise infer a latch.
    msb_idx = '0;
    for (int i = 0; i < N_BITS; i++) begin
      if (num2[i]) msb_idx = i[CNT_W-1:0];
    end
  end
`endif

  // Operands are only taken in IDLE, and never while reset is held.
  assign in_ready = (state_q == IDLE) && !rst;
  assign product  = acc_q;

  // Control FSM and datapath registers with registered out_valid/busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= num1;
            b_q     <= num2;
            acc_q   <= '0;
`ifdef GALOIS_MULT_EARLY_EXIT_EN
            cnt_q   <= msb_idx;
`else
            cnt_q   <= CNT_W'(N_BITS - 1);
`endif
            state_q <= RUN;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          acc_q <= acc_next;
          if (cnt_q == '0) begin
            state_q   <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule : galois_mult_serial

// File: tb/tb_galois_mult_serial.sv
// Self-checking bench for galois_mult_serial: directed corner cases plus
// randomized operands with random valid/ready gaps, checked against a
// wide-integer (a*b)%p reference model.
module tb_galois_mult_serial;
  import mimc_pkg::*;

  localparam int                N = N_BITS_DEFAULT;
  localparam logic [N-1:0]      P = BN254_PRIME;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] num1 = '0;
  logic [N-1:0] num2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] product;
  logic         busy;

  int checks = 0;
  int errors = 0;

  galois_mult_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference product using double-width integer arithmetic.
  function automatic logic [N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] wa, wb, wp, w;
    wa = {{N{1'b0}}, a};
    wb = {{N{1'b0}}, b};
    wp = {{N{1'b0}}, P};
    w  = (wa * wb) % wp;
    return w[N-1:0];
  endfunction

  // Cycles from the accepting edge to out_valid.
  function automatic int ref_latency(input logic [N-1:0] b);
`ifdef GALOIS_MULT_EARLY_EXIT_EN
    int m;
    m = 0;
    for (int i = 0; i < N; i++) if (b[i]) m = i;
    return m + 1;
`else
    return N;
`endif
  endfunction

  function automatic logic [N-1:0] rand_field();
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = (r << 32) | N'($urandom);
    return r % P;
  endfunction

  // Issue one multiplication, measure latency, hold backpressure, release.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input int hold, input string tag);
    logic [N-1:0] exp;
    int lat;
    exp = ref_mul(a, b);
    @(negedge clk);
    num1 = a;
    num2 = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    check({tag, "_in_ready"}, N'(in_ready), N'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    num1 = rand_field();
    num2 = rand_field();
    lat = 0;
    for (int i = 0; i < N + 20 && !out_valid; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!out_valid) check({tag, "_in_ready_run"}, N'(in_ready), N'(0));
    end
    check({tag, "_out_valid"}, N'(out_valid), N'(1));
    if (!out_valid) return;
    check({tag, "_latency"}, N'(lat), N'(ref_latency(b)));
    check({tag, "_product"}, product, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, N'(out_valid), N'(1));
      check({tag, "_hold_product"}, product, exp);
      check({tag, "_hold_in_ready"}, N'(in_ready), N'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_release_in_ready"}, N'(in_ready), N'(1));
    check({tag, "_release_valid"}, N'(out_valid), N'(0));
    check({tag, "_release_busy"}, N'(busy), N'(0));
  endtask

  initial begin
    // Reset state, checked while reset is still asserted.
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", N'(in_ready), N'(0));
    check("rst_out_valid", N'(out_valid), N'(0));
    check("rst_busy", N'(busy), N'(0));
    check("rst_product", product, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_in_ready", N'(in_ready), N'(1));

    // Directed cases.
    run_op(N'(3), N'(5), 0, "mul_3x5");
    run_op(P - 1, P - 1, 0, "mul_pm1_sq");
    run_op(P - 1, N'(2), 0, "mul_pm1_x2");
    run_op(N'(12345), N'(0), 0, "mul_by_0");
    run_op(N'(16'h1234), N'(1), 0, "mul_by_1");
    run_op(N'(6), N'(5), 10, "backpressure");

    // Abort mid-RUN with reset; nothing must come out for that operation.
    @(negedge clk);
    num1 = N'(11);
    num2 = N'(13);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (99) @(negedge clk);
    check("abort_busy_before", N'(busy), N'(1));
    rst = 1'b1;
    #1;
    check("abort_out_valid", N'(out_valid), N'(0));
    check("abort_busy", N'(busy), N'(0));
    check("abort_product", product, '0);
    check("abort_in_ready", N'(in_ready), N'(0));
    @(negedge clk);
    rst = 1'b0;
    run_op(N'(7), N'(9), 0, "after_abort");

    // Randomized operands and handshake gaps.
    for (int n = 0; n < 50; n++) begin
      logic [N-1:0] a, b;
      case ($urandom_range(0, 3))
        0: begin a = rand_field(); b = rand_field(); end
        1: begin a = N'($urandom); b = N'($urandom_range(0, 255)); end
        2: begin a = P - N'($urandom_range(1, 16)); b = P - N'($urandom_range(1, 16)); end
        default: begin a = rand_field(); b = N'($urandom); end
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(a, b, $urandom_range(0, 3), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_galois_mult_serial
